// File: rtl/inv_key_schedule_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inv_key_schedule_pkg
//  Description : Shared AES-128 constants, FSM encodings and GF(2^8)/S-box
//                helpers for the inverse key-schedule block.
//  Revision    : 1.0 - initial release
// ============================================================================
package inv_key_schedule_pkg;

    // AES-128 geometry
    localparam int AES_NR = 10;
    localparam int KEY_W  = 128;

    // Round-constant endpoints and the AES reduction polynomial (low byte)
    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;
    localparam logic [7:0] GF_POLY    = 8'h1B;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_EMIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Direction of one key-schedule step
    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_INV = 1'b1
    } step_dir_t;

    // AES forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte substitution: entry b lives at bit offset (255-b)*8 = {~b, 3'b000}
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Divide by x in GF(2^8); walks the round constants backwards
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ GF_POLY) >> 1) | 8'h80) : (b >> 1);
    endfunction

    // Key-schedule G: RotWord, SubWord, then XOR rc into the top byte
    function automatic logic [31:0] g_word(input logic [31:0] w, input logic [7:0] rc);
        logic [31:0] rot;
        rot = {w[23:0], w[31:24]};
        return {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    endfunction

endpackage : inv_key_schedule_pkg
`default_nettype wire

// File: rtl/inv_round_step.sv
`default_nettype none
// ============================================================================
//  Module      : inv_round_step
//  Description : Combinational single AES-128 key-schedule step. Forward mode
//                produces the next round key, inverse mode the previous one.
//                One G evaluation is shared by both directions.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_round_step
    import inv_key_schedule_pkg::*;
(
    input  logic [KEY_W-1:0] i_key,
    input  logic [7:0]       i_rc,
    input  step_dir_t        i_dir,
    output logic [KEY_W-1:0] o_key
);

    logic [31:0] w_w0;
    logic [31:0] w_w1;
    logic [31:0] w_w2;
    logic [31:0] w_w3;
    logic [31:0] w_prev_w3;
    logic [31:0] w_g_in;
    logic [31:0] w_g_out;
    logic [31:0] w_fwd0;
    logic [31:0] w_fwd1;
    logic [31:0] w_fwd2;
    logic [31:0] w_fwd3;

    assign w_w0 = i_key[127:96];
    assign w_w1 = i_key[95:64];
    assign w_w2 = i_key[63:32];
    assign w_w3 = i_key[31:0];

    // In inverse mode the G input is the previous key's last word, which is
    // recovered from the current key before G is applied
    assign w_prev_w3 = w_w3 ^ w_w2;
    assign w_g_in    = (i_dir == DIR_INV) ? w_prev_w3 : w_w3;
    assign w_g_out   = g_word(w_g_in, i_rc);

    // Forward recurrence: each word chains on the freshly produced one
    assign w_fwd0 = w_w0 ^ w_g_out;
    assign w_fwd1 = w_fwd0 ^ w_w1;
    assign w_fwd2 = w_fwd1 ^ w_w2;
    assign w_fwd3 = w_fwd2 ^ w_w3;

    // Select the direction; inverse words are pairwise XORs of the input
    always_comb begin
        o_key = {w_fwd0, w_fwd1, w_fwd2, w_fwd3};
        if (i_dir == DIR_INV) begin
            o_key = {w_w0 ^ w_g_out, w_w1 ^ w_w0, w_w2 ^ w_w1, w_prev_w3};
        end
    end

endmodule : inv_round_step
`default_nettype wire

// File: rtl/inv_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : inv_key_schedule
//  Description : Decryption-side AES-128 round-key provider. Streams round
//                keys NR..0 over a valid/ready handshake from a single key
//                register, optionally expanding a cipher key forward first.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_key_schedule
    import inv_key_schedule_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    input  logic             key_is_last,
    input  logic             start,
    output logic             busy,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             finish
);

    localparam logic [3:0] c_last_idx  = 4'(NR);
    localparam logic [3:0] c_prep_last = 4'(NR - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [KEY_W-1:0] r_round_key;
    logic [3:0]       r_round_idx;
    logic [7:0]       r_rcon;
    logic [3:0]       r_counter;
    logic [KEY_W-1:0] w_step_key;
    step_dir_t        w_step_dir;
    logic             w_accept;

    // A key leaves only on a handshake while presenting it
    assign w_accept   = (r_state == S_EMIT) && key_ready;
    assign w_step_dir = (r_state == S_EMIT) ? DIR_INV : DIR_FWD;

    inv_round_step u_step (
        .i_key (r_round_key),
        .i_rc  (r_rcon),
        .i_dir (w_step_dir),
        .o_key (w_step_key)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = key_is_last ? S_EMIT : S_PREP;
                end
            end
            S_PREP: begin
                if (r_counter == c_prep_last) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_accept && (r_round_idx == 4'd0)) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Key register, round index, round constant and expansion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_round_key <= '0;
            r_round_idx <= '0;
            r_rcon      <= RCON_FIRST;
            r_counter   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_round_key <= key;
                        if (key_is_last) begin
                            r_round_idx <= c_last_idx;
                            r_rcon      <= RCON_LAST;
                        end else begin
                            r_rcon      <= RCON_FIRST;
                            r_counter   <= '0;
                        end
                    end
                end
                S_PREP: begin
                    r_round_key <= w_step_key;
                    r_counter   <= r_counter + 4'd1;
                    if (r_counter == c_prep_last) begin
                        // Last forward step done; arm rcon for the first inverse step
                        r_round_idx <= c_last_idx;
                        r_rcon      <= RCON_LAST;
                    end else begin
                        r_rcon      <= xtime(r_rcon);
                    end
                end
                S_EMIT: begin
                    if (w_accept && (r_round_idx != 4'd0)) begin
                        r_round_key <= w_step_key;
                        r_round_idx <= r_round_idx - 4'd1;
                        r_rcon      <= inv_xtime(r_rcon);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign key_valid = (r_state == S_EMIT);
    assign finish    = (r_state == S_FIN);
    assign round_key = r_round_key;
    assign round_idx = r_round_idx;

endmodule : inv_key_schedule
`default_nettype wire
